// File: rtl/hs4_rx_mux_pkg.sv
// Shared defaults, channel-id width helper and per-channel handshake state encoding
// for the multi-channel 4-phase receive mux.
package hs4_rx_mux_pkg;

    localparam int unsigned DATA_W_DEF      = 8;
    localparam int unsigned N_CH_DEF        = 4;
    localparam int unsigned SYNC_STAGES_DEF = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } chan_state_e;

    // Channel id width; a single channel still carries a 1-bit id.
    function automatic int unsigned ch_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hs4_rx_chan.sv
// One 4-phase receive channel: request synchroniser, handshake FSM, holding
// register and pending flag that the top-level arbiter drains via grant.
module hs4_rx_chan
    import hs4_rx_mux_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic              clk_rx,
    input  logic              reset_n,
    input  logic              vi,
    input  logic [DATA_W-1:0] indata,
    input  logic              grant,
    output logic              snt,
    output logic              pending,
    output logic [DATA_W-1:0] hold_data
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   vi_s;
    chan_state_e            state_q;
    chan_state_e            state_d;
    logic                   capture_c;

    assign vi_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_rx or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], vi};
        end
    end

    // A word is only taken while the previous one has left the holding register.
    always_comb begin
        state_d   = state_q;
        capture_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (vi_s && !pending) begin
                    capture_c = 1'b1;
                    state_d   = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!vi_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_rx or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            snt       <= 1'b0;
            pending   <= 1'b0;
            hold_data <= '0;
        end else begin
            state_q <= state_d;
            snt     <= (state_d == ST_ACK);
            if (capture_c) begin
                pending   <= 1'b1;
                hold_data <= indata;
            end else if (grant) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/hs4_rx_mux.sv
// N_CH-channel 4-phase receive endpoint: per-channel capture, round-robin merge
// into one registered valid/ready stream tagged with the source channel.
module hs4_rx_mux
    import hs4_rx_mux_pkg::*;
#(
    parameter  int unsigned DATA_W      = DATA_W_DEF,
    parameter  int unsigned N_CH        = N_CH_DEF,
    parameter  int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
    localparam int unsigned CH_W        = ch_width(N_CH)
) (
    input  logic                   clk_rx,
    input  logic                   reset_n,
    input  logic [N_CH-1:0]        vi,
    input  logic [N_CH*DATA_W-1:0] indata,
    output logic [N_CH-1:0]        snt,
    output logic                   vo,
    output logic [DATA_W-1:0]      rdata,
    output logic [CH_W-1:0]        rch,
    input  logic                   rready,
    output logic                   busy
);

    logic [N_CH-1:0]   pending;
    logic [N_CH-1:0]   grant;
    logic [DATA_W-1:0] hold_data [N_CH];
    logic [CH_W-1:0]   rr_ptr_q;
    logic [N_CH-1:0]   rot_c;
    logic              win_valid_c;
    logic [CH_W-1:0]   win_ch_c;
    logic [DATA_W-1:0] win_data_c;
    logic [CH_W-1:0]   ptr_next_c;
    logic              load_c;

    for (genvar k = 0; k < N_CH; k++) begin : g_chan
        hs4_rx_chan #(
            .DATA_W      (DATA_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_chan (
            .clk_rx    (clk_rx),
            .reset_n   (reset_n),
            .vi        (vi[k]),
            .indata    (indata[k*DATA_W +: DATA_W]),
            .grant     (grant[k]),
            .snt       (snt[k]),
            .pending   (pending[k]),
            .hold_data (hold_data[k])
        );
    end

    assign load_c = !vo || rready;
    assign rot_c  = N_CH'({pending, pending} >> rr_ptr_q);

    // Round-robin: bit i of the rotated view is channel (ptr + i) mod N_CH.
    always_comb begin
        win_valid_c = 1'b0;
        win_ch_c    = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (!win_valid_c && rot_c[i]) begin
                win_valid_c = 1'b1;
                win_ch_c    = CH_W'((32'(rr_ptr_q) + i) % N_CH);
            end
        end
    end

    always_comb begin
        grant      = '0;
        win_data_c = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (win_ch_c == CH_W'(k)) begin
                win_data_c = hold_data[k];
                grant[k]   = load_c && win_valid_c;
            end
        end
    end

    assign ptr_next_c = (win_ch_c == CH_W'(N_CH - 1)) ? '0 : win_ch_c + CH_W'(1);

    always_ff @(posedge clk_rx or negedge reset_n) begin
        if (!reset_n) begin
            vo       <= 1'b0;
            rdata    <= '0;
            rch      <= '0;
            rr_ptr_q <= '0;
        end else if (load_c) begin
            vo <= win_valid_c;
            if (win_valid_c) begin
                rdata    <= win_data_c;
                rch      <= win_ch_c;
                rr_ptr_q <= ptr_next_c;
            end
        end
    end

    assign busy = (|pending) || vo;

endmodule

// File: tb/tb_hs4_rx_mux.sv
// Self-checking bench for hs4_rx_mux: cycle-level reference model of the
// handshake/arbitration rules, directed scenarios plus randomized 4-phase traffic.
module tb_hs4_rx_mux;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned S  = 2;
    localparam int unsigned S1 = 3;
    localparam int unsigned HL = 8192;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    vi;
    logic [N*DW-1:0] indata;
    logic [N-1:0]    snt;
    logic            vo;
    logic [DW-1:0]   rdata;
    logic [1:0]      rch;
    logic            rready;
    logic            busy;

    logic            vi1;
    logic [DW-1:0]   indata1;
    logic            snt1;
    logic            vo1;
    logic [DW-1:0]   rdata1;
    logic [0:0]      rch1;
    logic            rready1;
    logic            busy1;

    always #5 clk = ~clk;

    hs4_rx_mux #(.DATA_W(DW), .N_CH(N), .SYNC_STAGES(S)) dut (
        .clk_rx (clk), .reset_n (rst_n), .vi (vi), .indata (indata), .snt (snt),
        .vo (vo), .rdata (rdata), .rch (rch), .rready (rready), .busy (busy)
    );

    hs4_rx_mux #(.DATA_W(DW), .N_CH(1), .SYNC_STAGES(S1)) dut1 (
        .clk_rx (clk), .reset_n (rst_n), .vi (vi1), .indata (indata1), .snt (snt1),
        .vo (vo1), .rdata (rdata1), .rch (rch1), .rready (rready1), .busy (busy1)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: channel handshake flag, pending word, output slot, rr pointer.
    bit            m_ack  [N];
    bit            m_pend [N];
    logic [DW-1:0] m_hold [N];
    bit            m_vo;
    logic [DW-1:0] m_rdata;
    int            m_rch;
    int            m_ptr;
    bit            hist   [N][HL];
    int            m_n;

    function automatic void model_reset();
        for (int k = 0; k < N; k++) begin
            m_ack[k]  = 1'b0;
            m_pend[k] = 1'b0;
            m_hold[k] = '0;
        end
        m_vo = 1'b0; m_rdata = '0; m_rch = 0; m_ptr = 0; m_n = 0;
    endfunction

    function automatic void model_edge();
        bit load, any, vs;
        int w;
        load = !m_vo || rready;
        any  = 1'b0;
        w    = 0;
        for (int i = 0; i < N; i++) begin
            int c = (m_ptr + i) % N;
            if (!any && m_pend[c]) begin any = 1'b1; w = c; end
        end
        // Requests as seen S edges late; captures only into an empty holding slot.
        for (int k = 0; k < N; k++) begin
            vs = (m_n >= int'(S)) ? hist[k][m_n - int'(S)] : 1'b0;
            hist[k][m_n] = vi[k];
            if (!m_ack[k] && vs && !m_pend[k]) begin
                m_ack[k]  = 1'b1;
                m_pend[k] = 1'b1;
                m_hold[k] = indata[k*DW +: DW];
            end else if (m_ack[k] && !vs) begin
                m_ack[k] = 1'b0;
            end
        end
        if (load) begin
            m_vo = any;
            if (any) begin
                m_rdata   = m_hold[w];
                m_rch     = w;
                m_ptr     = (w + 1) % N;
                m_pend[w] = 1'b0;
            end
        end
        m_n++;
    endfunction

    function automatic logic [N-1:0] m_snt();
        logic [N-1:0] v;
        for (int k = 0; k < N; k++) v[k] = m_ack[k];
        return v;
    endfunction

    function automatic bit m_busy();
        bit b = m_vo;
        for (int k = 0; k < N; k++) b = b | m_pend[k];
        return b;
    endfunction

    task automatic compare_all();
        check("snt", 32'(snt), 32'(m_snt()));
        check("vo", 32'(vo), 32'(m_vo));
        check("busy", 32'(busy), 32'(m_busy()));
        if (m_vo) begin
            check("rdata", 32'(rdata), 32'(m_rdata));
            check("rch", 32'(rch), 32'(m_rch));
        end
    endtask

    // One clock: advance model at the edge, compare just after, return at negedge.
    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_edge();
        else       model_reset();
        #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic wait_snt(input int k, input logic level, output int e);
        e = 0;
        while (snt[k] !== level && e < 40) begin
            cycle();
            e++;
        end
        if (snt[k] !== level) check("wait_snt", 32'(snt[k]), 32'(level));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    // Randomized 4-phase transmitters driven from the model's view of snt.
    int           ph  [N];
    int           dly [N];
    logic [N-1:0] agent_en;

    task automatic drive_agents();
        for (int k = 0; k < N; k++) begin
            if (agent_en[k]) begin
                case (ph[k])
                    0: begin
                        if (dly[k] > 0) dly[k]--;
                        else begin
                            indata[k*DW +: DW] = DW'($urandom);
                            vi[k] = 1'b1;
                            ph[k] = 1;
                        end
                    end
                    1: if (m_ack[k]) begin vi[k] = 1'b0; ph[k] = 2; end
                    default: if (!m_ack[k]) begin ph[k] = 0; dly[k] = $urandom_range(0, 3); end
                endcase
            end
        end
    endtask

    task automatic agents_init();
        for (int k = 0; k < N; k++) begin ph[k] = 0; dly[k] = 0; end
    endtask

    initial begin
        int e;
        rst_n = 1'b0; vi = '0; indata = '0; rready = 1'b0;
        vi1 = 1'b0; indata1 = '0; rready1 = 1'b1;
        agent_en = '0;
        agents_init();
        model_reset();
        #12;
        check("rst_snt", 32'(snt), 32'(0));
        check("rst_vo", 32'(vo), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_rdata", 32'(rdata), 32'(0));
        check("rst_snt1", 32'(snt1), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Single channel instance, deeper synchroniser.
        vi1 = 1'b1; indata1 = 8'h3C;
        e = 0;
        while (snt1 !== 1'b1 && e < 20) begin cycle(); e++; end
        check("lat1_snt", 32'(e), 32'(S1 + 1));
        cycle();
        check("n1_vo", 32'(vo1), 32'(1));
        check("n1_rdata", 32'(rdata1), 32'(8'h3C));
        check("n1_rch", 32'(rch1), 32'(0));
        vi1 = 1'b0;
        e = 0;
        while (snt1 !== 1'b0 && e < 20) begin cycle(); e++; end
        check("lat1_drop", 32'(e), 32'(S1 + 1));
        check("n1_vo_done", 32'(vo1), 32'(0));
        check("n1_busy_done", 32'(busy1), 32'(0));

        // Single word on channel 0.
        rready = 1'b1;
        indata[7:0] = 8'hFF;
        vi[0] = 1'b1;
        wait_snt(0, 1'b1, e);
        check("lat_snt", 32'(e), 32'(S + 1));
        cycle();
        check("sw_vo", 32'(vo), 32'(1));
        check("sw_rdata", 32'(rdata), 32'(8'hFF));
        check("sw_rch", 32'(rch), 32'(0));
        vi[0] = 1'b0;
        wait_snt(0, 1'b0, e);
        check("lat_drop", 32'(e), 32'(S + 1));

        // Fairness: all channels request together from a fresh pointer.
        do_reset();
        indata = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        vi = '1;
        rready = 1'b1;
        wait_snt(0, 1'b1, e);
        for (int i = 0; i < N; i++) begin
            cycle();
            check("fair_rch", 32'(rch), 32'(i));
            check("fair_rdata", 32'(rdata), 32'(8'hA0 + i));
        end
        check("fair_ptr", 32'(dut.rr_ptr_q), 32'(0));
        vi = '0;
        wait_snt(0, 1'b0, e);
        repeat (3) cycle();

        // Backpressure on channel 1: output slot and holding register both full.
        do_reset();
        rready = 1'b0;
        indata[15:8] = 8'h11; vi[1] = 1'b1; wait_snt(1, 1'b1, e);
        vi[1] = 1'b0; wait_snt(1, 1'b0, e);
        indata[15:8] = 8'h22; vi[1] = 1'b1; wait_snt(1, 1'b1, e);
        vi[1] = 1'b0; wait_snt(1, 1'b0, e);
        indata[15:8] = 8'h33; vi[1] = 1'b1;
        repeat (6) cycle();
        check("bp_snt", 32'(snt[1]), 32'(0));
        check("bp_vo", 32'(vo), 32'(1));
        check("bp_rdata", 32'(rdata), 32'(8'h11));
        rready = 1'b1;
        cycle();
        check("bp_next", 32'(rdata), 32'(8'h22));
        cycle();
        check("bp_cap", 32'(snt[1]), 32'(1));
        cycle();
        check("bp_last_vo", 32'(vo), 32'(1));
        check("bp_last", 32'(rdata), 32'(8'h33));
        vi[1] = 1'b0;
        wait_snt(1, 1'b0, e);

        // Back-to-back: channels 2 and 3 streaming with a consumer always ready.
        agents_init();
        agent_en = 4'b1100;
        for (int c = 0; c < 300; c++) begin
            drive_agents();
            cycle();
        end
        agent_en = '0;
        vi = '0;
        repeat (10) cycle();

        // Reset in the middle of a handshake.
        rready = 1'b0;
        indata[7:0] = 8'h5A;
        vi[0] = 1'b1;
        wait_snt(0, 1'b1, e);
        cycle();
        check("mr_pre_vo", 32'(vo), 32'(1));
        rst_n = 1'b0;
        #1;
        check("mr_snt", 32'(snt), 32'(0));
        check("mr_vo", 32'(vo), 32'(0));
        check("mr_busy", 32'(busy), 32'(0));
        model_reset();
        cycle();
        rst_n = 1'b1;
        wait_snt(0, 1'b1, e);
        check("mr_lat", 32'(e), 32'(S + 1));
        vi[0] = 1'b0;
        wait_snt(0, 1'b0, e);
        repeat (4) cycle();

        // Randomized traffic on all channels with a stalling consumer.
        agents_init();
        agent_en = '1;
        for (int c = 0; c < 2000; c++) begin
            drive_agents();
            rready = ($urandom_range(0, 9) < 7);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
